// File: rtl/backscatter_sequencer.sv
// Backscatter frame sequencer: sends an alternating preamble, then fetches
// payload bytes one at a time and shifts each out LSB first on trigger_out.
// Latency: first preamble cycle follows the accepted start; bits are BIT_CYCLES each.
// Backpressure: data_ready is high only in FETCH; a missing byte for GAP_CYCLES aborts with underrun.
//
// Ports:
//   clock, reset      - system clock (rising edge), asynchronous active-low reset
//   start, byte_count - frame request (honoured in IDLE) and payload length
//   data_in, data_valid / data_ready - upstream byte handshake
//   trigger_out       - registered enable to the toggle generator
//   busy, done, underrun - status; done/underrun are single-cycle pulses
module backscatter_sequencer #(
    parameter int BIT_CYCLES    = 2560,
    parameter int PREAMBLE_BITS = 32,
    parameter int GAP_CYCLES    = 640
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_count,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       trigger_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_FETCH,
        S_BIT,
        S_DONE
    } state_t;

    localparam logic [15:0] CYC_LAST = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cyc_q,   cyc_d;     // cycles elapsed inside the current bit
    logic [15:0] gap_q,   gap_d;     // cycles spent waiting in FETCH
    logic [7:0]  pbit_q,  pbit_d;    // preamble bit index
    logic [2:0]  bitn_q,  bitn_d;    // payload bit index within the byte
    logic [7:0]  rem_q,   rem_d;     // payload bytes still to send
    logic [7:0]  shift_q, shift_d;   // current byte, bit 0 is on the air
    logic        trig_q,  trig_d;
    logic        unr_q,   unr_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            gap_q   <= '0;
            pbit_q  <= '0;
            bitn_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            trig_q  <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            gap_q   <= gap_d;
            pbit_q  <= pbit_d;
            bitn_q  <= bitn_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            trig_q  <= trig_d;
            unr_q   <= unr_d;
        end
    end

    // trigger_out is computed one cycle ahead so the registered value lines
    // up with the state it belongs to and only moves on bit/state boundaries.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        gap_d   = gap_q;
        pbit_d  = pbit_q;
        bitn_d  = bitn_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        trig_d  = trig_q;
        unr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                trig_d = 1'b0;
                if (start) begin
                    rem_d   = byte_count;
                    cyc_d   = '0;
                    pbit_d  = '0;
                    trig_d  = 1'b1;          // preamble bit 0 is a 1
                    state_d = S_PREAMBLE;
                end
            end

            S_PREAMBLE: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (pbit_q == PRE_LAST) begin
                        trig_d  = 1'b0;
                        gap_d   = '0;
                        state_d = (rem_q != 8'd0) ? S_FETCH : S_DONE;
                    end else begin
                        pbit_d = pbit_q + 8'd1;
                        // even preamble bits are 1, odd are 0
                        trig_d = pbit_q[0];
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end

            S_FETCH: begin
                trig_d = 1'b0;
                // data_ready is high throughout FETCH, so valid alone completes the handshake
                if (data_valid) begin
                    shift_d = data_in;
                    trig_d  = data_in[0];
                    cyc_d   = '0;
                    bitn_d  = '0;
                    state_d = S_BIT;
                end else if (gap_q == GAP_LAST) begin
                    unr_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            S_BIT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bitn_q == 3'd7) begin
                        rem_d   = rem_q - 8'd1;
                        trig_d  = 1'b0;
                        gap_d   = '0;
                        state_d = (rem_q != 8'd1) ? S_FETCH : S_DONE;
                    end else begin
                        bitn_d  = bitn_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        trig_d  = shift_q[1];
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end

            S_DONE: begin
                trig_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                trig_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_ready  = (state_q == S_FETCH);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign underrun    = unr_q;
    assign trigger_out = trig_q;

endmodule

// File: tb/tb_backscatter_sequencer.sv
module tb_backscatter_sequencer;

    localparam int BC  = 4;
    localparam int PB  = 2;
    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte_count;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       trigger_out;
    logic       busy;
    logic       done;
    logic       underrun;

    backscatter_sequencer #(
        .BIT_CYCLES   (BC),
        .PREAMBLE_BITS(PB),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .trigger_out(trigger_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs {trigger, ready, busy, done, underrun},
    // starting with the cycle after start, plus the inputs to drive then.
    logic [4:0] exp_q[$];
    logic       dv_q[$];
    logic [7:0] din_q[$];

    logic [7:0] fr_bytes[8];
    int         fr_delay[8];   // FETCH cycles before valid; >= GAP means starve

    function automatic logic [4:0] obs();
        return {trigger_out, data_ready, busy, done, underrun};
    endfunction

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (trig,rdy,busy,done,unr)", tag, o, e);
        end
    endtask

    task automatic push(input logic t, input logic r, input logic b, input logic d,
                        input logic u, input logic dv, input logic [7:0] di);
        exp_q.push_back({t, r, b, d, u});
        dv_q.push_back(dv);
        din_q.push_back(di);
    endtask

    // Frame timeline from the rules: alternating preamble, then per byte a
    // wait in FETCH followed by 8 LSB-first bits, then a DONE cycle and IDLE.
    task automatic build(input int n, input bit hold);
        bit und;
        logic [7:0] b;
        exp_q.delete();
        dv_q.delete();
        din_q.delete();
        und = 1'b0;
        for (int p = 0; p < PB; p++)
            for (int c = 0; c < BC; c++)
                push((p % 2) == 0, 1'b0, 1'b1, 1'b0, 1'b0, hold, fr_bytes[0]);
        for (int i = 0; i < n; i++) begin
            if (!und) begin
                b = fr_bytes[i];
                if (fr_delay[i] >= GAP) begin
                    for (int k = 0; k < GAP; k++)
                        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
                    und = 1'b1;
                end else begin
                    for (int k = 0; k < fr_delay[i]; k++)
                        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
                    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, b);
                    for (int k = 0; k < 8; k++)
                        for (int c = 0; c < BC; c++)
                            push(b[k], 1'b0, 1'b1, 1'b0, 1'b0, hold,
                                 (i + 1 < n) ? fr_bytes[i + 1] : b);
                end
            end
        end
        push(1'b0, 1'b0, 1'b1, 1'b1, und, 1'b0, 8'h00);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_frame(input string tag, input int n, input bit hold,
                             input int start_at, input int abort_at);
        build(n, hold);
        @(negedge clock);
        start      = 1'b1;
        byte_count = 8'(n);
        data_valid = hold;
        data_in    = fr_bytes[0];
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clock);
            start      = (c == start_at);
            byte_count = 8'($urandom);   // only sampled on an accepted start
            if (c == abort_at) begin
                reset      = 1'b0;
                data_valid = 1'b0;
                #1 check({tag, "_rst_now"}, obs(), 5'b0);
                @(negedge clock);
                check({tag, "_rst_next"}, obs(), 5'b0);
                reset = 1'b1;
                @(negedge clock);
                check({tag, "_rst_idle"}, obs(), 5'b0);
                return;
            end
            check($sformatf("%s_c%0d", tag, c), obs(), exp_q[c]);
            data_valid = dv_q[c];
            data_in    = din_q[c];
        end
        start      = 1'b0;
        data_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit hold;
        reset      = 1'b0;
        start      = 1'b0;
        byte_count = 8'd0;
        data_in    = 8'd0;
        data_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("reset", obs(), 5'b0);
        reset = 1'b1;
        @(negedge clock);
        check("idle", obs(), 5'b0);

        // One byte A5 with valid tied high
        fr_bytes[0] = 8'hA5; fr_delay[0] = 0;
        run_frame("a5", 1, 1'b1, -1, -1);

        // Zero-length frame: preamble then done, never ready
        run_frame("zero", 0, 1'b0, -1, -1);

        // Second byte never arrives: underrun after GAP cycles
        fr_bytes[0] = 8'h3C; fr_delay[0] = 0;
        fr_bytes[1] = 8'h81; fr_delay[1] = GAP;
        run_frame("under", 2, 1'b0, -1, -1);

        // start pulsed mid-bit is ignored
        fr_bytes[0] = 8'h5A; fr_delay[0] = 0;
        run_frame("restart", 1, 1'b0, PB * BC + 1 + 5, -1);

        // Late valid (2 cycles) in both FETCH windows
        fr_bytes[0] = 8'hC3; fr_delay[0] = 2;
        fr_bytes[1] = 8'h96; fr_delay[1] = 2;
        run_frame("late", 2, 1'b0, -1, -1);

        // Reset inside the third payload bit, then a full fresh frame
        fr_bytes[0] = 8'hF0; fr_delay[0] = 0;
        run_frame("abort", 1, 1'b0, -1, PB * BC + 1 + 2 * BC + 1);
        fr_bytes[0] = 8'h0F; fr_delay[0] = 1;
        run_frame("after", 1, 1'b0, -1, -1);

        // Valid held high across several consecutive fetches
        for (int i = 0; i < 3; i++) begin
            fr_bytes[i] = 8'(8'h11 * (i + 3));
            fr_delay[i] = 0;
        end
        run_frame("hold3", 3, 1'b1, -1, -1);

        for (int r = 0; r < 20; r++) begin
            n    = $urandom_range(0, 3);
            hold = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                fr_bytes[i] = 8'($urandom);
                fr_delay[i] = hold ? 0 : $urandom_range(0, GAP);
            end
            run_frame($sformatf("rnd%0d", r), n, hold, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
